// File: rtl/wave_pkg.sv
// Shared constants, state/segment encodings and helpers for the waveform sequencer.
package wave_pkg;

    localparam int SEG_LEN = 50;   // samples per waveform segment
    localparam int NUM_SEG = 4;    // number of segments held in the LUT
    localparam int DATA_W  = 12;   // sample width
    localparam int ADDR_W  = 8;    // LUT address width
    localparam int DIV_W   = 16;   // rate divider width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEG_NOISE = 2'd0,
        SEG_HIGH  = 2'd1,
        SEG_LOW   = 2'd2,
        SEG_MED   = 2'd3
    } seg_e;

    // Next segment in sweep order, wrapping from the last segment back to 0.
    function automatic logic [1:0] next_seg(input logic [1:0] seg, input int num_seg);
        if (int'(seg) == num_seg - 1) begin
            return 2'd0;
        end else begin
            return seg + 2'd1;
        end
    endfunction

endpackage

// File: rtl/wave_sequencer_if.sv
// Control, LUT and sample bus of the waveform sequencer.
interface wave_sequencer_if #(
    parameter int DATA_W = wave_pkg::DATA_W,
    parameter int ADDR_W = wave_pkg::ADDR_W,
    parameter int DIV_W  = wave_pkg::DIV_W
);
    logic              start;
    logic              stop;
    logic [1:0]        seg_sel;
    logic              sweep;
    logic [DIV_W-1:0]  rate_div;
    logic [ADDR_W-1:0] lut_index;
    logic [DATA_W-1:0] lut_value;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              seg_wrap;

    modport master (
        output start, stop, seg_sel, sweep, rate_div, lut_value,
        input  lut_index, sample_out, sample_valid, busy, seg_wrap
    );

    modport slave (
        input  start, stop, seg_sel, sweep, rate_div, lut_value,
        output lut_index, sample_out, sample_valid, busy, seg_wrap
    );
endinterface

// File: rtl/wave_sequencer_tick_gen.sv
// Sample-rate divider: one tick every div+1 enabled cycles, the first one
// in the very first enabled cycle after a clear.
module tick_gen #(
    parameter int DIV_W = wave_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    // cnt_q is the cycle phase since the last tick; it returns to 0 after
    // reaching div, so phase 0 is the tick cycle.
    logic [DIV_W-1:0] cnt_q;

    assign tick = en && (cnt_q == {DIV_W{1'b0}});

    // Phase counter: cleared on start, advances only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DIV_W{1'b0}};
        end else if (clr) begin
            cnt_q <= {DIV_W{1'b0}};
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_q <= {DIV_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end
endmodule

// File: rtl/wave_sequencer.sv
// Waveform sequencer: walks LUT segments at a programmable rate and returns
// the LUT data as strobed samples. SEG_LEN*NUM_SEG must fit in 2**ADDR_W.
module wave_sequencer #(
    parameter int SEG_LEN = wave_pkg::SEG_LEN,
    parameter int NUM_SEG = wave_pkg::NUM_SEG,
    parameter int DATA_W  = wave_pkg::DATA_W,
    parameter int ADDR_W  = wave_pkg::ADDR_W,
    parameter int DIV_W   = wave_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    wave_sequencer_if.slave  bus
);
    import wave_pkg::*;

    state_e            state_q, state_d;
    logic              rst_done_q;
    logic [1:0]        seg_q, seg_d;
    logic              sweep_q;
    logic [DIV_W-1:0]  rate_q;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] lut_index_q, lut_index_d;
    logic              seg_wrap_q, seg_wrap_d;
    logic [1:0]        pend_q;
    logic [DATA_W-1:0] sample_q;
    logic              valid_q;
    logic              busy_q;
    logic              start_ok_s, tick_en_s, tick_s, last_s;

    // Start is ignored in the first cycle out of reset and when stop coincides.
    assign start_ok_s = bus.start && !bus.stop && rst_done_q && (state_q == IDLE);
    // A stop cycle suppresses the tick that would otherwise be due.
    assign tick_en_s  = (state_q == RUN) && !bus.stop;
    assign last_s     = (offset_q == ADDR_W'(SEG_LEN - 1));

    tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en_s),
        .clr   (start_ok_s),
        .div   (rate_q),
        .tick  (tick_s)
    );

    // Next-state logic for IDLE/RUN/DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok_s) state_d = RUN;   else state_d = IDLE;
            RUN:     if (bus.stop)   state_d = DRAIN; else state_d = RUN;
            DRAIN:   if (pend_q == 2'b00) state_d = IDLE; else state_d = DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Segment/offset walk and LUT address generation.
    always_comb begin
        offset_d    = offset_q;
        seg_d       = seg_q;
        lut_index_d = lut_index_q;
        seg_wrap_d  = 1'b0;
        if (start_ok_s) begin
            offset_d = {ADDR_W{1'b0}};
            seg_d    = bus.seg_sel;
        end else if (tick_s) begin
            lut_index_d = ADDR_W'(int'(seg_q) * SEG_LEN + int'(offset_q));
            seg_wrap_d  = last_s;
            if (last_s) begin
                offset_d = {ADDR_W{1'b0}};
                seg_d    = sweep_q ? next_seg(seg_q, NUM_SEG) : seg_q;
            end else begin
                offset_d = offset_q + ADDR_W'(1);
            end
        end else begin
            offset_d = offset_q;
        end
    end

    // FSM state, reset-release flag and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Run configuration latched at start, plus address walk registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= 2'd0;
            sweep_q     <= 1'b0;
            rate_q      <= {DIV_W{1'b0}};
            offset_q    <= {ADDR_W{1'b0}};
            lut_index_q <= {ADDR_W{1'b0}};
            seg_wrap_q  <= 1'b0;
        end else begin
            if (start_ok_s) begin
                sweep_q <= bus.sweep;
                rate_q  <= bus.rate_div;
            end else begin
                sweep_q <= sweep_q;
                rate_q  <= rate_q;
            end
            seg_q       <= seg_d;
            offset_q    <= offset_d;
            lut_index_q <= lut_index_d;
            seg_wrap_q  <= seg_wrap_d;
        end
    end

    // Read pipeline: pend_q[0] = address issued, pend_q[1] = LUT data valid now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 2'b00;
            sample_q <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            pend_q  <= {pend_q[0], tick_s};
            valid_q <= pend_q[1];
            if (pend_q[1]) begin
                sample_q <= bus.lut_value;
            end else begin
                sample_q <= sample_q;
            end
        end
    end

    assign bus.lut_index    = lut_index_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.seg_wrap     = seg_wrap_q;
endmodule
